// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags
// and an accumulator; 4-bit opcode, parametrised operand width.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] OP_A   = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_DEC = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_ACC = 4'b1011;
  localparam logic [3:0] OP_CLR = 4'b1100;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic             adv;

  assign adv       = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv;
  assign out_valid = s2_valid;

  logic [WIDTH-1:0] add_l;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             add_v;
  logic             sub_v;
  logic [SHW-1:0]   amt;
  logic             big;
  logic [WIDTH-1:0] ny;
  logic             nc;
  logic             nv;
  logic             nill;
  logic [4:0]       nf;

  // Adder is shared by add/inc/acc, subtractor by sub/dec.
  always_comb begin
    add_l = s1_a;
    add_r = s1_b;
    sub_r = s1_b;
    if (s1_op == OP_INC) add_r = ONE;
    if (s1_op == OP_ACC) begin
      add_l = acc;
      add_r = s1_a;
    end
    if (s1_op == OP_DEC) sub_r = ONE;
    sum   = {1'b0, add_l} + {1'b0, add_r};
    dif   = {1'b0, s1_a} - {1'b0, sub_r};
    add_v = (add_l[WIDTH-1] == add_r[WIDTH-1]) &&
            (sum[WIDTH-1] != add_l[WIDTH-1]);
    sub_v = (s1_a[WIDTH-1] != sub_r[WIDTH-1]) &&
            (dif[WIDTH-1] != s1_a[WIDTH-1]);
    amt   = s1_b[SHW-1:0];
    big   = int'(amt) >= WIDTH;
  end

  always_comb begin
    ny   = '0;
    nc   = 1'b0;
    nv   = 1'b0;
    nill = 1'b0;
    case (s1_op)
      OP_A:   ny = s1_a;
      OP_B:   ny = s1_b;
      OP_AND: ny = s1_a & s1_b;
      OP_OR:  ny = s1_a | s1_b;
      OP_XOR: ny = s1_a ^ s1_b;
      OP_SHL: ny = big ? '0 : (s1_a << amt);
      OP_SHR: ny = big ? '0 : (s1_a >> amt);
      OP_CLR: ny = acc;
      OP_ADD, OP_INC, OP_ACC: begin
        ny = sum[WIDTH-1:0];
        nc = sum[WIDTH];
        nv = add_v;
      end
      OP_SUB, OP_DEC: begin
        ny = dif[WIDTH-1:0];
        nc = dif[WIDTH];
        nv = sub_v;
      end
      default: nill = 1'b1;
    endcase
    nf = {nill, nv, nc, ny[WIDTH-1], ny == '0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      y        <= '0;
      flags    <= '0;
      acc      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op_code;
          s1_a  <= a;
          s1_b  <= b;
        end
      end
      // acc moves only with the beat, so a stall never touches it.
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          y     <= ny;
          flags <= nf;
          if (s1_op == OP_ACC) acc <= sum[WIDTH-1:0];
          if (s1_op == OP_CLR) acc <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomised checks for alu_pipe at WIDTH=8.
// Expected values are hand-computed or from an independent model.
module tb_alu_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_code;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [4:0] flags;
  logic [7:0] acc;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o,
                       input logic [7:0] x,
                       input logic [7:0] z);
    in_valid = 1'b1;
    op_code  = o;
    a        = x;
    b        = z;
  endtask

  // {flags, y} for the legacy opcodes
  function automatic logic [12:0] model(input logic [3:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] z);
    logic [7:0] r;
    logic c;
    logic v;
    int s;
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (o)
      4'd0: r = x;
      4'd1: begin
        r = x + z;
        c = (int'(x) + int'(z)) > 255;
        s = int'($signed(x)) + int'($signed(z));
        v = (s > 127) || (s < -128);
      end
      4'd2: begin
        r = x - z;
        c = x < z;
        s = int'($signed(x)) - int'($signed(z));
        v = (s > 127) || (s < -128);
      end
      4'd3: r = x & z;
      4'd4: r = x | z;
      4'd5: begin
        r = x + 8'd1;
        c = (x == 8'hFF);
        v = (x == 8'h7F);
      end
      4'd6: begin
        r = x - 8'd1;
        c = (x == 8'h00);
        v = (x == 8'h80);
      end
      default: r = z;
    endcase
    return {1'b0, v, c, r[7], r == 8'h00, r};
  endfunction

  logic [12:0] exp_q[$];
  logic [12:0] e;
  int pushed;
  int popped;
  int guard;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_code   = 4'h0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", flags, 0);
    chk("rst_acc", acc, 0);
    chk("rst_in_ready", in_ready, 1);

    // add overflow, then subtract borrow
    drive(4'b0001, 8'h7F, 8'h01);
    step();
    chk("add_not_yet", out_valid, 0);
    drive(4'b0010, 8'h00, 8'h01);
    step();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_y", y, 8'h80);
    chk("add_flags", flags, 5'b01010);
    step();
    chk("sub_valid", out_valid, 1);
    chk("sub_y", y, 8'hFF);
    chk("sub_flags", flags, 5'b00110);
    step();
    chk("sub_drained", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    drive(4'b0000, 8'h11, 8'h99);
    step();
    drive(4'b0111, 8'h99, 8'h22);
    chk("bp_ready2", in_ready, 1);
    step();
    drive(4'b0011, 8'hF0, 8'h3C);
    chk("bp_full", in_ready, 0);
    chk("bp_y0", y, 8'h11);
    step();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_y", y, 8'h11);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_y1", y, 8'h22);
    chk("bp_v1", out_valid, 1);
    step();
    chk("bp_y2", y, 8'h30);
    chk("bp_v2", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // accumulator chain
    drive(4'b1100, 8'h00, 8'h00);
    step();
    drive(4'b1011, 8'd5, 8'h00);
    step();
    drive(4'b1011, 8'd10, 8'h00);
    chk("clr_y", y, 8'h00);
    chk("clr_flags", flags, 5'b00001);
    step();
    drive(4'b1011, 8'd250, 8'h00);
    chk("acc5_y", y, 8'd5);
    chk("acc5_acc", acc, 8'd5);
    step();
    in_valid = 1'b0;
    chk("acc15_y", y, 8'd15);
    chk("acc15_acc", acc, 8'd15);
    step();
    chk("acc9_y", y, 8'd9);
    chk("acc9_flags", flags, 5'b00100);
    chk("acc9_acc", acc, 8'd9);
    drive(4'b1100, 8'h00, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk("clr9_y", y, 8'd9);
    chk("clr9_acc", acc, 8'd0);

    // shifts and illegal
    drive(4'b1000, 8'h81, 8'd3);
    step();
    drive(4'b1001, 8'h81, 8'd7);
    step();
    drive(4'b1110, 8'h5A, 8'hA5);
    chk("shl_y", y, 8'h08);
    chk("shl_flags", flags, 5'b00000);
    step();
    in_valid = 1'b0;
    chk("shr_y", y, 8'h01);
    step();
    chk("ill_y", y, 8'h00);
    chk("ill_flags", flags, 5'b10001);
    step();

    // reset with both stages full and acc non-zero
    out_ready = 1'b0;
    drive(4'b1011, 8'd7, 8'h00);
    step();
    drive(4'b1011, 8'd1, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk("stall_acc", acc, 8'd7);
    chk("stall_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_acc", acc, 0);
    chk("arst_y", y, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    step();
    chk("post_rst_valid2", out_valid, 0);

    // randomised legacy-opcode regression
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      op_code   = 4'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      #3;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("reg_extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("reg_y", y, e[7:0]);
          chk("reg_flags", flags, e[12:8]);
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op_code, a, b));
        pushed++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      #3;
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("drain_y", y, e[7:0]);
        chk("drain_flags", flags, e[12:8]);
        popped++;
      end
      step();
      guard++;
    end
    chk("reg_count", popped, pushed);
    chk("reg_left", exp_q.size(), 0);
    chk("reg_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
